// File: rtl/ir_cmd_decoder.sv
// Qualifies held NEC words from irReceiver and turns each new stable word into one action.
// Execute pulses appear STABLE_CYCLES clocks after the change is sampled; there is no backpressure.
module ir_cmd_decoder #(
  parameter int          STABLE_CYCLES = 1024,
  parameter logic [15:0] ADDR          = 16'h20DF,
  parameter logic [15:0] UP_CODE       = 16'h02FD,
  parameter logic [15:0] DOWN_CODE     = 16'h827D,
  parameter logic [15:0] LEFT_CODE     = 16'hE01F,
  parameter logic [15:0] RIGHT_CODE    = 16'h609F,
  parameter logic [15:0] START_CODE    = 16'h0000
) (
  input  logic        CLOCK_50,
  input  logic        reset_n,
  input  logic [31:0] word,
  input  logic        game_tick,
  input  logic        game_active,
  input  logic        dir_clear,
  output logic [1:0]  dir,
  output logic        start_pulse,
  output logic        dir_reject,
  output logic        cmd_err
);

  typedef enum logic [1:0] {WAIT, QUALIFY, LOCKED} state_t;

  localparam logic [15:0] LAST_CNT = 16'(STABLE_CYCLES - 1);

  state_t      state;
  logic [31:0] word_r;
  logic [15:0] stab_cnt;
  logic [1:0]  pend_dir;

  logic       execute;
  logic       addr_ok;
  logic       is_start;
  logic       is_dir;
  logic [1:0] new_dir;
  logic [1:0] ref_dir;
  logic       reversal;

  always_comb begin
    is_dir  = 1'b1;
    new_dir = 2'b11;
    if (word[15:0] == UP_CODE)         new_dir = 2'b00;
    else if (word[15:0] == DOWN_CODE)  new_dir = 2'b01;
    else if (word[15:0] == LEFT_CODE)  new_dir = 2'b10;
    else if (word[15:0] == RIGHT_CODE) new_dir = 2'b11;
    else                               is_dir  = 1'b0;
  end

  assign execute  = (state == QUALIFY) && (word == word_r) && (stab_cnt == LAST_CNT);
  assign addr_ok  = (word[31:16] == ADDR);
  assign is_start = (word[15:0] == START_CODE);
  // A tick in the same cycle commits pend_dir, so the reversal test must be against it.
  assign ref_dir  = game_tick ? pend_dir : dir;
  assign reversal = (new_dir == {ref_dir[1], ~ref_dir[0]});

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state       <= WAIT;
      word_r      <= '0;
      stab_cnt    <= '0;
      pend_dir    <= 2'b11;
      dir         <= 2'b11;
      start_pulse <= 1'b0;
      dir_reject  <= 1'b0;
      cmd_err     <= 1'b0;
    end else begin
      start_pulse <= 1'b0;
      dir_reject  <= 1'b0;
      cmd_err     <= 1'b0;
      word_r      <= word;

      if (word != word_r) begin
        stab_cnt <= '0;
        state    <= QUALIFY;
      end else if (state == QUALIFY && !execute) begin
        stab_cnt <= stab_cnt + 16'd1;
      end else if (execute) begin
        state <= LOCKED;
      end

      if (game_tick) dir <= pend_dir;

      if (execute) begin
        if (!addr_ok)        cmd_err     <= 1'b1;
        else if (is_start)   start_pulse <= 1'b1;
        else if (is_dir) begin
          if (game_active && !dir_clear) begin
            if (reversal) dir_reject <= 1'b1;
            else          pend_dir   <= new_dir;
          end
        end else             cmd_err     <= 1'b1;
      end

      // New game: direction clear wins over both the tick and any execute.
      if (dir_clear) begin
        dir      <= 2'b11;
        pend_dir <= 2'b11;
      end
    end
  end

endmodule

// File: tb/tb_ir_cmd_decoder.sv
// Directed bench for ir_cmd_decoder with a rule-level model compared on every falling edge.
module tb_ir_cmd_decoder;

  localparam int STAB = 4;

  logic        CLOCK_50 = 1'b0;
  logic        reset_n;
  logic [31:0] word;
  logic        game_tick, game_active, dir_clear;
  logic [1:0]  dir;
  logic        start_pulse, dir_reject, cmd_err;

  int total = 0;
  int bad   = 0;

  ir_cmd_decoder #(.STABLE_CYCLES(STAB)) dut (
    .CLOCK_50    (CLOCK_50),
    .reset_n     (reset_n),
    .word        (word),
    .game_tick   (game_tick),
    .game_active (game_active),
    .dir_clear   (dir_clear),
    .dir         (dir),
    .start_pulse (start_pulse),
    .dir_reject  (dir_reject),
    .cmd_err     (cmd_err)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic check(input string name, input logic [1:0] act, input logic [1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Classify a word by the key table: -1 error, 0..3 direction, 4 start.
  function automatic int classify(input logic [31:0] w);
    if (w[31:16] != 16'h20DF) return -1;
    case (w[15:0])
      16'h0000: return 4;
      16'h02FD: return 0;
      16'h827D: return 1;
      16'hE01F: return 2;
      16'h609F: return 3;
      default:  return -1;
    endcase
  endfunction

  int          opp [4] = '{1, 0, 3, 2};
  logic [31:0] m_prev;
  int          m_run;
  logic        m_armed;
  logic [1:0]  m_dir, m_pend;
  logic        e_start, e_rej, e_err;
  int          kind;
  logic        exec_now;
  logic [1:0]  ref_d;

  always_comb begin
    kind     = classify(word);
    exec_now = (word == m_prev) && m_armed && (m_run + 1 == STAB);
    ref_d    = game_tick ? m_pend : m_dir;
  end

  always @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      m_prev  <= '0;
      m_run   <= 0;
      m_armed <= 1'b0;
      m_dir   <= 2'd3;
      m_pend  <= 2'd3;
      e_start <= 1'b0;
      e_rej   <= 1'b0;
      e_err   <= 1'b0;
    end else begin
      m_prev  <= word;
      e_start <= 1'b0;
      e_rej   <= 1'b0;
      e_err   <= 1'b0;
      if (word != m_prev) begin
        m_run   <= 0;
        m_armed <= 1'b1;
      end else if (m_armed) begin
        m_run <= m_run + 1;
        if (exec_now) m_armed <= 1'b0;
      end
      if (game_tick) m_dir <= m_pend;
      if (exec_now) begin
        if (kind < 0)       e_err   <= 1'b1;
        else if (kind == 4) e_start <= 1'b1;
        else if (game_active && !dir_clear) begin
          if (kind == opp[ref_d]) e_rej  <= 1'b1;
          else                    m_pend <= kind[1:0];
        end
      end
      if (dir_clear) begin
        m_dir  <= 2'd3;
        m_pend <= 2'd3;
      end
    end
  end

  always @(negedge CLOCK_50) begin
    check("dir", dir, m_dir);
    check("start_pulse", {1'b0, start_pulse}, {1'b0, e_start});
    check("dir_reject", {1'b0, dir_reject}, {1'b0, e_rej});
    check("cmd_err", {1'b0, cmd_err}, {1'b0, e_err});
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge CLOCK_50);
  endtask

  task automatic tick();
    game_tick = 1'b1;
    cyc(1);
    game_tick = 1'b0;
  endtask

  initial begin
    reset_n     = 1'b0;
    word        = '0;
    game_tick   = 1'b0;
    game_active = 1'b0;
    dir_clear   = 1'b0;
    cyc(2);
    check("reset_dir", dir, 2'b11);
    check("reset_pulses", {start_pulse | dir_reject, cmd_err}, 2'b00);
    reset_n = 1'b1;
    cyc(2);

    // Start key: change sampled at edge k, pulse visible after edge k+4.
    word = 32'h20DF0000;
    cyc(4);
    check("start_early", {1'b0, start_pulse}, 2'b00);
    cyc(1);
    check("start_at_latency", {1'b0, start_pulse}, 2'b01);
    cyc(1);
    check("start_one_cycle", {1'b0, start_pulse}, 2'b00);
    cyc(6);

    // UP while active: pending only until a tick.
    game_active = 1'b1;
    word = 32'h20DF02FD;
    cyc(6);
    check("up_before_tick", dir, 2'b11);
    tick();
    check("up_after_tick", dir, 2'b00);

    // DOWN against UP is a reversal.
    word = 32'h20DF827D;
    cyc(5);
    check("down_reject", {1'b0, dir_reject}, 2'b01);
    cyc(1);
    tick(); tick(); tick();
    check("down_dir_held", dir, 2'b00);

    // LEFT pending, then DOWN executes on the same edge as a tick.
    word = 32'h20DFE01F;
    cyc(6);
    word = 32'h20DF827D;
    cyc(4);
    tick();
    check("sim_tick_dir", dir, 2'b10);
    check("sim_tick_noreject", {1'b0, dir_reject}, 2'b00);
    cyc(2);
    tick();
    check("sim_tick_next", dir, 2'b01);

    // Foreign address and unknown code.
    word = 32'h12340000;
    cyc(5);
    check("bad_addr_err", {1'b0, cmd_err}, 2'b01);
    cyc(1);
    word = 32'h20DFFFFF;
    cyc(5);
    check("bad_code_err", {1'b0, cmd_err}, 2'b01);
    cyc(1);

    // Glitching word never settles long enough.
    for (int i = 0; i < 8; i++) begin
      word = (i % 2 == 0) ? 32'h20DF0000 : 32'h20DFE01F;
      cyc(2);
    end
    word = 32'h20DF5555;
    cyc(6);

    // Clear coincides with a tick and a LEFT execute.
    word = 32'h20DFE01F;
    cyc(4);
    game_tick = 1'b1;
    dir_clear = 1'b1;
    cyc(1);
    game_tick = 1'b0;
    dir_clear = 1'b0;
    check("clear_dir", dir, 2'b11);
    cyc(2);
    tick();
    check("clear_pend", dir, 2'b11);

    // Reset pulse in the middle of qualification.
    word = 32'h20DF0000;
    cyc(2);
    #2 reset_n = 1'b0;
    #1;
    check("midreset_dir", dir, 2'b11);
    check("midreset_pulses", {start_pulse | dir_reject, cmd_err}, 2'b00);
    cyc(1);
    reset_n = 1'b1;
    cyc(10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
